c64_phase_timing: RTL and testbench

//  Downstream consumer of the NCO dot clock (dot_clock, ~7.88 MHz, a register
//  bit in the clk domain). Turns its rising edges into single-cycle clock

---
 rtl/c64_phase_timing.sv | 88 ++++++++
 tb/tb_c64_phase_timing.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/c64_phase_timing.sv
// rtl/c64_phase_timing.sv - dot clock edge strobes, pixel/phi0 timing, optional raster counters
// Optional feature macro: PHASE_RASTER_COUNT_EN (cycle/raster counters, line_ce/frame_ce).
module c64_phase_timing #(
  parameter int DOTS_PER_PHI    = 8,
  parameter int CYCLES_PER_LINE = 63,
  parameter int LINES_PER_FRAME = 312
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dot_clock,
  output logic       dot_ce,
  output logic [2:0] pix,
  output logic       phi0,
  output logic       phi_rise_ce,
  output logic       cycle_ce,
  output logic [5:0] cycle,
  output logic [8:0] raster,
  output logic       line_ce,
  output logic       frame_ce
);

  localparam logic [2:0] PIX_MAX  = 3'(DOTS_PER_PHI - 1);
  localparam logic [2:0] PIX_HALF = 3'(DOTS_PER_PHI / 2);

  logic       r_dot_q;
  logic       w_edge;
  logic       w_pix_wrap;
  logic [2:0] w_pix_next;

  assign w_edge     = dot_clock & ~r_dot_q;
  assign w_pix_wrap = (pix == PIX_MAX);
  assign w_pix_next = w_pix_wrap ? 3'd0 : pix + 3'd1;

  // dot_q follows dot_clock even in reset, so a level already high at release is not an edge
  always_ff @(posedge clk) begin
    r_dot_q <= dot_clock;
    if (reset) begin
      dot_ce      <= 1'b0;
      pix         <= 3'd0;
      phi0        <= 1'b0;
      phi_rise_ce <= 1'b0;
      cycle_ce    <= 1'b0;
    end else begin
      dot_ce      <= w_edge;
      phi_rise_ce <= w_edge & (w_pix_next == PIX_HALF);
      cycle_ce    <= w_edge & w_pix_wrap;
      if (w_edge) begin
        pix  <= w_pix_next;
        phi0 <= (w_pix_next >= PIX_HALF);
      end
    end
  end

`ifdef PHASE_RASTER_COUNT_EN
  localparam logic [5:0] CYC_MAX = 6'(CYCLES_PER_LINE - 1);
  localparam logic [8:0] RAS_MAX = 9'(LINES_PER_FRAME - 1);

  logic w_cycle_step;
  logic w_line_step;
  logic w_frame_step;

  assign w_cycle_step = w_edge & w_pix_wrap;
  assign w_line_step  = w_cycle_step & (cycle == CYC_MAX);
  assign w_frame_step = w_line_step & (raster == RAS_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle    <= 6'd0;
      raster   <= 9'd0;
      line_ce  <= 1'b0;
      frame_ce <= 1'b0;
    end else begin
      line_ce  <= w_line_step;
      frame_ce <= w_frame_step;
      if (w_cycle_step)
        cycle <= (cycle == CYC_MAX) ? 6'd0 : cycle + 6'd1;
      if (w_line_step)
        raster <= (raster == RAS_MAX) ? 9'd0 : raster + 9'd1;
    end
  end
`else
  assign cycle    = 6'd0;
  assign raster   = 9'd0;
  assign line_ce  = 1'b0;
  assign frame_ce = 1'b0;
`endif

endmodule

// File: tb/tb_c64_phase_timing.sv
// tb/tb_c64_phase_timing.sv - randomized bench for c64_phase_timing against a dot-count model
module tb_c64_phase_timing;

`ifdef PHASE_RASTER_COUNT_EN
  localparam bit RASTER_ON = 1'b1;
`else
  localparam bit RASTER_ON = 1'b0;
`endif

  // default PAL instance and a tiny instance so frame wraps are reachable quickly
  localparam int AD = 8, AC = 63, AL = 312;
  localparam int BD = 4, BC = 3,  BL = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dot_clock = 1'b1;

  logic       a_dot_ce, a_phi0, a_phi_rise_ce, a_cycle_ce, a_line_ce, a_frame_ce;
  logic [2:0] a_pix;
  logic [5:0] a_cycle;
  logic [8:0] a_raster;
  logic       b_dot_ce, b_phi0, b_phi_rise_ce, b_cycle_ce, b_line_ce, b_frame_ce;
  logic [2:0] b_pix;
  logic [5:0] b_cycle;
  logic [8:0] b_raster;

  c64_phase_timing #(.DOTS_PER_PHI(AD), .CYCLES_PER_LINE(AC), .LINES_PER_FRAME(AL)) dut_a (
    .clk(clk), .reset(reset), .dot_clock(dot_clock),
    .dot_ce(a_dot_ce), .pix(a_pix), .phi0(a_phi0), .phi_rise_ce(a_phi_rise_ce),
    .cycle_ce(a_cycle_ce), .cycle(a_cycle), .raster(a_raster),
    .line_ce(a_line_ce), .frame_ce(a_frame_ce)
  );

  c64_phase_timing #(.DOTS_PER_PHI(BD), .CYCLES_PER_LINE(BC), .LINES_PER_FRAME(BL)) dut_b (
    .clk(clk), .reset(reset), .dot_clock(dot_clock),
    .dot_ce(b_dot_ce), .pix(b_pix), .phi0(b_phi0), .phi_rise_ce(b_phi_rise_ce),
    .cycle_ce(b_cycle_ce), .cycle(b_cycle), .raster(b_raster),
    .line_ce(b_line_ce), .frame_ce(b_frame_ce)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // model: everything follows from the number of dots seen since reset
  logic m_prev = 1'b0;
  logic m_ce   = 1'b0;
  int   m_n    = 0;

  int  cyc = 0;
  int  last_ce = -1;
  bit  spacing_on = 1'b0;
  int  cnt_line = 0;
  int  cnt_ce = 0;
  int  cnt_b_frame = 0;

  function automatic logic [31:0] exp_strobes(int d, int c, int l);
    logic s_ce, s_rise, s_cyc, s_line, s_frame;
    s_ce    = m_ce;
    s_rise  = m_ce && (m_n % d == d / 2);
    s_cyc   = m_ce && (m_n % d == 0);
    s_line  = RASTER_ON && m_ce && (m_n % (d * c) == 0);
    s_frame = RASTER_ON && m_ce && (m_n % (d * c * l) == 0);
    return {27'd0, s_ce, s_rise, s_cyc, s_line, s_frame};
  endfunction

  function automatic logic [31:0] exp_pix(int d);
    int p;
    p = m_n % d;
    return {28'd0, (p >= d / 2) ? 1'b1 : 1'b0, 3'(p)};
  endfunction

  function automatic logic [31:0] exp_count(int d, int c, int l);
    int cy, ra;
    cy = RASTER_ON ? (m_n / d) % c : 0;
    ra = RASTER_ON ? (m_n / (d * c)) % l : 0;
    return {17'd0, 9'(ra), 6'(cy)};
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_ce = 1'b0;
      m_n  = 0;
    end else begin
      m_ce = dot_clock & ~m_prev;
      if (m_ce) m_n++;
    end
    m_prev = dot_clock;
    @(negedge clk);
    cyc++;
    check_eq("a_strobes", {27'd0, a_dot_ce, a_phi_rise_ce, a_cycle_ce, a_line_ce, a_frame_ce}, exp_strobes(AD, AC, AL));
    check_eq("a_pix_phi0", {28'd0, a_phi0, a_pix}, exp_pix(AD));
    check_eq("a_cycle_raster", {17'd0, a_raster, a_cycle}, exp_count(AD, AC, AL));
    check_eq("b_strobes", {27'd0, b_dot_ce, b_phi_rise_ce, b_cycle_ce, b_line_ce, b_frame_ce}, exp_strobes(BD, BC, BL));
    check_eq("b_pix_phi0", {28'd0, b_phi0, b_pix}, exp_pix(BD));
    check_eq("b_cycle_raster", {17'd0, b_raster, b_cycle}, exp_count(BD, BC, BL));
    if (a_line_ce) cnt_line++;
    if (b_frame_ce) cnt_b_frame++;
    if (a_dot_ce) begin
      cnt_ce++;
      if (spacing_on && last_ce >= 0) check_eq("ce_spacing", 32'(cyc - last_ce), 32'd18);
      last_ce = cyc;
    end
  endtask

  task automatic drive_dot(input int hi, input int lo);
    dot_clock = 1'b1;
    repeat (hi) step();
    dot_clock = 1'b0;
    repeat (lo) step();
  endtask

  task automatic do_reset(input logic lvl, input int len);
    reset = 1'b1;
    dot_clock = lvl;
    repeat (len) step();
    reset = 1'b0;
  endtask

  initial begin
    // high level at release must not count as an edge
    do_reset(1'b1, 3);
    cnt_ce = 0;
    repeat (5) step();
    check_eq("no_spurious_ce", 32'(cnt_ce), 32'd0);
    dot_clock = 1'b0;
    step();
    dot_clock = 1'b1;
    step();
    check_eq("first_ce_latency", {31'd0, a_dot_ce}, 32'd1);
    check_eq("first_ce_pix", {29'd0, a_pix}, 32'd1);

    // 16 edges, toggling every 9 clks
    do_reset(1'b0, 2);
    cnt_ce = 0;
    last_ce = -1;
    spacing_on = 1'b1;
    repeat (16) drive_dot(9, 9);
    spacing_on = 1'b0;
    check_eq("ce_count_16", 32'(cnt_ce), 32'd16);
    check_eq("pix_after_16", {29'd0, a_pix}, 32'd0);

    // one full raster line
    do_reset(1'b0, 2);
    cnt_line = 0;
    repeat (AD * AC) drive_dot($urandom_range(1, 3), $urandom_range(1, 3));
    check_eq("line_ce_count", 32'(cnt_line), RASTER_ON ? 32'd1 : 32'd0);
    check_eq("line_cycle", {26'd0, a_cycle}, 32'd0);
    check_eq("line_raster", {23'd0, a_raster}, RASTER_ON ? 32'd1 : 32'd0);

    // reset mid-line at pix=5, cycle=30
    for (int i = 0; i < 1000 && (m_n % (AD * AC)) != 30 * AD + 5; i++)
      drive_dot(2, 2);
    check_eq("reached_pix5", {29'd0, a_pix}, 32'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("reset_outputs", {a_dot_ce, a_pix, a_phi0, a_phi_rise_ce, a_cycle_ce, a_cycle, a_raster, a_line_ce, a_frame_ce}, 24'd0);
    repeat (3) drive_dot(2, 2);

    // randomized dot spacing with occasional resets
    cnt_b_frame = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)), $urandom_range(1, 3));
      drive_dot($urandom_range(1, 8), $urandom_range(1, 8));
    end
    check_eq("b_frames_seen", 32'(cnt_b_frame > 0), RASTER_ON ? 32'd1 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
